// File: rtl/int_to_ieee_converter.sv
// int_to_ieee_converter
// Iterative 32-bit integer to IEEE-754 single-precision converter with
// round-to-nearest-even. One conversion in flight; valid/ready on both sides.
// State flow: IDLE -> NORM (left-justify magnitude) -> ROUND -> DONE -> IDLE.
// Zero operands skip NORM/ROUND and go straight to DONE with +0.
// Optional build macro: INT2FP_UNSIGNED_EN treats in_data as unsigned.
module int_to_ieee_converter #(
    parameter int NORM_STEP = 1,   // max left-shift per NORM cycle: 1, 2, 4 or 8
    parameter int BIAS      = 127  // single-precision exponent bias
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_inexact
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_NORM  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Leading-zero count of a 32-bit word (32 when the word is zero).
    function automatic logic [5:0] f_clz(input logic [31:0] v);
        logic [5:0] n;
        logic       found;
        n     = 6'd0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + 6'd1;
                end
            end
        end
        return n;
    endfunction

    logic [1:0]  r_state;
    logic [31:0] r_mag;
    logic [7:0]  r_exp;
    logic        r_sign;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic        r_out_inexact;

    logic        w_in_sign;
    logic [31:0] w_in_mag;
    logic [5:0]  w_lz;
    logic [5:0]  w_shamt;
    logic [22:0] w_mant;
    logic        w_guard;
    logic        w_sticky;
    logic        w_round_up;
    logic [23:0] w_mant_sum;
    logic [22:0] w_mant_final;
    logic [7:0]  w_exp_final;
    logic        w_inexact;

    // Operand decode: sign and absolute magnitude of the incoming integer.
    always_comb begin
        w_in_sign = 1'b0;
        w_in_mag  = in_data;
`ifdef INT2FP_UNSIGNED_EN
        w_in_sign = 1'b0;
        w_in_mag  = in_data;
`else
        w_in_sign = in_data[31];
        if (in_data[31]) begin
            // 0x80000000 negates to itself, which is the correct magnitude.
            w_in_mag = ~in_data + 32'd1;
        end else begin
            w_in_mag = in_data;
        end
`endif
    end

    // Normalisation step size: never shift past the leading one.
    always_comb begin
        w_lz    = f_clz(r_mag);
        w_shamt = 6'd0;
        if (w_lz < 6'(NORM_STEP)) begin
            w_shamt = w_lz;
        end else begin
            w_shamt = 6'(NORM_STEP);
        end
    end

    // Round-to-nearest-even on the left-justified magnitude.
    always_comb begin
        w_mant       = r_mag[30:8];
        w_guard      = r_mag[7];
        w_sticky     = |r_mag[6:0];
        w_round_up   = w_guard & (w_sticky | w_mant[0]);
        w_mant_sum   = {1'b0, w_mant} + {23'd0, w_round_up};
        w_mant_final = w_mant_sum[22:0];
        w_inexact    = w_guard | w_sticky;
        if (w_mant_sum[23]) begin
            // All-ones mantissa rolled over: mantissa is zero, bump exponent.
            w_exp_final = r_exp + 8'd1;
        end else begin
            w_exp_final = r_exp;
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_mag         <= 32'd0;
            r_exp         <= 8'd0;
            r_sign        <= 1'b0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_out_data    <= 32'd0;
            r_out_inexact <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_sign     <= w_in_sign;
                        r_mag      <= w_in_mag;
                        r_exp      <= 8'(BIAS + 31);
                        r_in_ready <= 1'b0;
                        if (w_in_mag == 32'd0) begin
                            // Zero has no leading one; emit +0 directly.
                            r_state       <= ST_DONE;
                            r_out_valid   <= 1'b1;
                            r_out_data    <= 32'd0;
                            r_out_inexact <= 1'b0;
                        end else begin
                            r_state <= ST_NORM;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_NORM: begin
                    if (r_mag[31]) begin
                        r_state <= ST_ROUND;
                    end else begin
                        r_mag <= r_mag << w_shamt;
                        r_exp <= r_exp - {2'b00, w_shamt};
                    end
                end
                ST_ROUND: begin
                    r_out_data    <= {r_sign, w_exp_final, w_mant_final};
                    r_out_inexact <= w_inexact;
                    r_exp         <= w_exp_final;
                    r_out_valid   <= 1'b1;
                    r_state       <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_inexact = r_out_inexact;

endmodule

// File: tb/tb_int_to_ieee_converter.sv
// Self-checking bench for int_to_ieee_converter: directed test-plan vectors
// with known results, backpressure, mid-conversion reset, then randomized
// operands checked against an arithmetic reference model (result, inexact
// flag and latency).
module tb_int_to_ieee_converter;

    localparam int STEP = 1;
    localparam int BIAS = 127;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_inexact;

    int checks;
    int failures;

    int_to_ieee_converter #(.NORM_STEP(STEP), .BIAS(BIAS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_inexact (out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer value rounded to 24 significant bits, RNE.
    task automatic ref_model(input logic [31:0] d, output logic [31:0] f,
                             output logic inx, output int lat);
        longint mag, q, rem, half;
        int     p, drop, e, lz;
        logic   s;
`ifdef INT2FP_UNSIGNED_EN
        s   = 1'b0;
        mag = longint'({32'd0, d});
`else
        s   = d[31];
        if (s) mag = 64'sh1_0000_0000 - longint'({32'd0, d});
        else   mag = longint'({32'd0, d});
`endif
        if (mag == 0) begin
            f = 32'd0; inx = 1'b0; lat = 1;
        end else begin
            p = 0;
            for (int i = 0; i < 33; i++) if (((mag >> i) & 64'sd1) != 0) p = i;
            e = BIAS + p;
            if (p <= 23) begin
                q   = mag << (23 - p);
                inx = 1'b0;
            end else begin
                drop = p - 23;
                q    = mag >> drop;
                rem  = mag - (q << drop);
                half = 64'sd1 << (drop - 1);
                inx  = (rem != 0);
                if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
                if (q == (64'sd1 << 24)) begin
                    q = q >> 1;
                    e = e + 1;
                end
            end
            f   = {s, e[7:0], q[22:0]};
            lz  = 31 - p;
            lat = (lz + STEP - 1) / STEP + 1 + 2;
        end
    endtask

    // One full conversion: accept, latency, result, optional hold, handshake.
    task automatic do_convert(input logic [31:0] d, input int hold,
                              output logic [31:0] got, output logic got_inx);
        logic [31:0] exp_f;
        logic        exp_i;
        int          exp_lat;
        int          cyc;
        int          n;
        ref_model(d, exp_f, exp_i, exp_lat);
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_value("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_value("latency", cyc, exp_lat);
        check_value("out_data", out_data, exp_f);
        check_value("out_inexact", {31'd0, out_inexact}, {31'd0, exp_i});
        check_value("in_ready_busy", {31'd0, in_ready}, 32'd0);
        got     = out_data;
        got_inx = out_inexact;
        for (int k = 0; k < hold; k++) begin
            // A competing request while busy must be ignored.
            in_valid = 1'b1;
            in_data  = $urandom;
            @(negedge clk);
            check_value("hold_valid", {31'd0, out_valid}, 32'd1);
            check_value("hold_data", out_data, exp_f);
            check_value("hold_inexact", {31'd0, out_inexact}, {31'd0, exp_i});
            check_value("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_value("valid_drop", {31'd0, out_valid}, 32'd0);
        check_value("in_ready_after", {31'd0, in_ready}, 32'd1);
    endtask

    typedef struct {
        logic [31:0] din;
        logic [31:0] dout;
        logic        inx;
        int          hold;
    } vec_t;

    initial begin
        vec_t        vecs[$];
        logic [31:0] got;
        logic        gi;
        logic [31:0] v;
        int          seen;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_value("rst_out_data", out_data, 32'd0);
        check_value("rst_out_inexact", {31'd0, out_inexact}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_value("rst_in_ready", {31'd0, in_ready}, 32'd1);

`ifdef INT2FP_UNSIGNED_EN
        vecs.push_back('{32'hFFFF_FFFF, 32'h4F80_0000, 1'b1, 0});
        vecs.push_back('{32'h8000_0000, 32'h4F00_0000, 1'b0, 0});
        vecs.push_back('{32'h0000_0001, 32'h3F80_0000, 1'b0, 0});
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, 0});
        vecs.push_back('{32'h0000_0064, 32'h42C8_0000, 1'b0, 10});
`else
        vecs.push_back('{32'h0000_0001, 32'h3F80_0000, 1'b0, 0});
        vecs.push_back('{32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 0});
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, 0});
        vecs.push_back('{32'h8000_0000, 32'hCF00_0000, 1'b0, 0});
        vecs.push_back('{32'h7FFF_FFFF, 32'h4F00_0000, 1'b1, 0});
        vecs.push_back('{32'h0100_0001, 32'h4B80_0000, 1'b1, 0});
        vecs.push_back('{32'h0100_0003, 32'h4B80_0002, 1'b1, 0});
        vecs.push_back('{32'h0000_0064, 32'h42C8_0000, 1'b0, 10});
`endif
        foreach (vecs[i]) begin
            do_convert(vecs[i].din, vecs[i].hold, got, gi);
            check_value("golden_data", got, vecs[i].dout);
            check_value("golden_inexact", {31'd0, gi}, {31'd0, vecs[i].inx});
        end

        // Reset in the middle of NORM discards the conversion.
        in_data  = 32'h0000_0001;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_value("midrst_valid_async", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_value("midrst_no_output", seen, 32'd0);
        check_value("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        do_convert(32'h0000_0002, 0, got, gi);
        check_value("post_rst_data", got, 32'h4000_0000);

        // Randomized operands of varied magnitude and sign.
        for (int i = 0; i < 200; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = ~v + 32'd1;
            do_convert(v, $urandom_range(0, 3), got, gi);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_to_ieee_converter.md
Name: int_to_ieee_converter

Overview:
- Iterative sequential converter from 32-bit two's-complement integer to IEEE-754 single precision.
- Round-to-nearest-even.
- Produces the normalized floats consumed by the FPU adder/subtractor datapath; the producer end of the float interface.
- Valid/ready handshake on input and output; one conversion in flight.

Parameters:
- NORM_STEP, 1, max left-shift bits per NORM cycle; legal 1, 2, 4, 8.
- BIAS, 127, exponent bias; do not change for single precision.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data valid
- in_ready  output  1  converter can accept (high only in IDLE)
- in_data  input  32  signed integer operand
- out_valid  output  1  out_data valid; held until taken
- out_ready  input  1  downstream accepts result
- out_data  output  32  IEEE-754 result {sign, exp[7:0], mant[22:0]}
- out_inexact  output  1  result was rounded (guard|sticky nonzero)

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset:
  - State goes to IDLE.
  - in_ready=1 after release; out_valid=0, out_data=0, out_inexact=0.
  - Internal mag/exp/sign cleared.
  - Reset mid-conversion discards the operation; no output is produced.
- Accept: in_valid&in_ready at a rising edge.
  - sign=in_data[31].
  - mag=|in_data| as 32-bit unsigned; 0x80000000 gives mag 0x80000000.
  - exp=BIAS+31=158.
- IDLE:
  - in_ready=1.
  - On accept with mag==0 -> DONE; out_data=0x00000000 (+0, sign forced 0), inexact=0.
  - On accept with mag!=0 -> NORM.
- NORM:
  - in_ready=0.
  - If mag[31]==1 -> ROUND.
  - Else shift mag left by min(NORM_STEP, leading-zero count of mag) and decrement exp by the same amount; stay in NORM.
  - With NORM_STEP=1, NORM lasts lz+1 cycles.
- ROUND:
  - mant=mag[30:8], guard=mag[7], sticky=|mag[6:0].
  - Round up iff guard&(sticky|mant[0]).
  - Mantissa carry-out (mant all ones +1) -> mant=0, exp+=1.
  - out_inexact=guard|sticky.
  - Register out_data -> DONE.
- DONE:
  - out_valid=1; out_data/out_inexact stable while out_valid&!out_ready.
  - On out_ready -> IDLE; out_valid low next cycle.
  - in_ready rises the cycle after the handshake; no same-cycle accept from DONE.
- Latency (NORM_STEP=1):
  - Nonzero input: out_valid asserted lz+3 edges after the accept edge (lz = leading zeros of mag, 0..31).
  - Zero input: out_valid asserted 1 edge after accept.
- No overflow, NaN or denormal is possible for a 32-bit integer source; exponent range is 127..159.
- in_valid while in_ready=0 is ignored; upstream holds data.

Optional Feature:
- Macro: INT2FP_UNSIGNED_EN.
- Defined:
  - in_data is treated as unsigned; sign=0, mag=in_data.
  - Largest result 0xFFFFFFFF -> 0x4F800000 (exp 159 after round carry).
- Undefined: two's-complement signed as above.

Test Plan:
- in_data=0x00000001 -> out_data=0x3F800000, inexact=0, out_valid 34 cycles after accept; in_data=0xFFFFFFFF -> 0xBF800000.
- in_data=0x00000000 -> out_data=0x00000000 one cycle after accept; in_data=0x80000000 -> 0xCF000000, inexact=0, 3 cycles.
- in_data=0x7FFFFFFF -> round-up with mantissa carry -> out_data=0x4F000000, inexact=1; in_data=0x01000001 (tie, even) -> 0x4B800000, inexact=1; in_data=0x01000003 (tie, odd) -> 0x4B800002, inexact=1.
- Backpressure: in_data=0x00000064 converted, out_ready low 10 cycles -> out_valid and out_data=0x42C80000 held stable, in_ready=0 throughout; second in_valid ignored until IDLE.
- rst_n pulsed low during NORM of in_data=0x00000001 -> out_valid stays 0, in_ready=1 after release; next input 0x00000002 -> 0x40000000.
- With INT2FP_UNSIGNED_EN: in_data=0xFFFFFFFF -> 0x4F800000, inexact=1; in_data=0x80000000 -> 0x4F000000.
